maze_loader: RTL and testbench



---
 rtl/maze_pkg.sv | 19 +
 rtl/maze_row_assembler.sv | 44 ++++
 rtl/maze_loader.sv | 97 +++++++++
 tb/tb_maze_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze bitmap loader.
package maze_pkg;

    localparam int MAZE_X = 40;
    localparam int MAZE_Y = 20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } loader_state_t;

    // Number of stream words that make up one maze row.
    function automatic int words_per_row(input int size_x, input int word_w);
        return size_x / word_w;
    endfunction

endpackage

// File: rtl/maze_row_assembler.sv
// Collects stream words into one full maze row, leftmost cell first.
module maze_row_assembler
    import maze_pkg::*;
#(
    parameter int size_x = MAZE_X,
    parameter int WORD_W = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                clear,
    input  logic                accept,
    input  logic [WORD_W-1:0]   in_data,
    output logic [0:size_x-1]   row_buf,
    output logic                row_full
);

    localparam int WPR = words_per_row(size_x, WORD_W);
    localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WPR - 1);

    logic [WCW-1:0] wcnt;

    // The word being accepted is the last one of the row.
    assign row_full = (wcnt == WLAST);

    // Drop each accepted word into its slot; the word MSB lands on the lower cell index.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wcnt    <= '0;
            row_buf <= '0;
        end else if (clear) begin
            wcnt    <= '0;
            row_buf <= '0;
        end else if (accept) begin
            for (int w = 0; w < WPR; w++) begin
                if (wcnt == WCW'(w)) begin
                    row_buf[w*WORD_W +: WORD_W] <= in_data;
                end
            end
            wcnt <= row_full ? '0 : wcnt + 1'b1;
        end
    end

endmodule

// File: rtl/maze_loader.sv
// Writer side of the renderer's maze bitmap: streamed full loads plus idle-time cell edits.
module maze_loader
    import maze_pkg::*;
#(
    parameter int size_y = MAZE_Y,
    parameter int size_x = MAZE_X,
    parameter int WORD_W = 8
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        start,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        cell_we,
    input  logic [$clog2(size_x)-1:0]   cell_x,
    input  logic [$clog2(size_y)-1:0]   cell_y,
    input  logic                        cell_val,
    output logic [0:size_x-1]           maze [size_y-1:0],
    output logic                        busy,
    output logic                        done
);

    localparam int YW = $clog2(size_y);
    localparam logic [YW-1:0] LAST_ROW = YW'(size_y - 1);

    loader_state_t      state;
    logic [YW-1:0]      row;
    logic [0:size_x-1]  row_buf;
    logic               row_full;
    logic               accept;
    logic               clear;
    logic               cell_ok;

    // Handshake and status flags are decoded purely from the state register.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == COMMIT);
    assign done     = (state == DONE);

    assign accept  = in_valid && in_ready;
    assign clear   = (state == IDLE) && start;
    assign cell_ok = cell_we && (int'(cell_x) < size_x) && (int'(cell_y) < size_y);

    maze_row_assembler #(
        .size_x (size_x),
        .WORD_W (WORD_W)
    ) u_row_asm (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .clear    (clear),
        .accept   (accept),
        .in_data  (in_data),
        .row_buf  (row_buf),
        .row_full (row_full)
    );

    // Load sequencing, row commits and idle cell edits; start always beats a cell write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            row   <= '0;
            maze  <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        state <= LOAD;
                    end else if (cell_ok) begin
                        maze[cell_y][cell_x] <= cell_val;
                    end
                end
                LOAD: begin
                    if (accept && row_full) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    maze[row] <= row_buf;
                    if (row == LAST_ROW) begin
                        state <= DONE;
                    end else begin
                        row   <= row + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_loader.sv
// Self-checking bench for maze_loader: per-cycle model compare plus directed literal checks.
module tb_maze_loader;
    import maze_pkg::*;

    localparam int SX     = MAZE_X;
    localparam int SY     = MAZE_Y;
    localparam int WW     = 8;
    localparam int WPR    = SX / WW;
    localparam int NWORDS = WPR * SY;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b1;
    logic           start = 1'b0;
    logic [WW-1:0]  in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           cell_we = 1'b0;
    logic [5:0]     cell_x = '0;
    logic [4:0]     cell_y = '0;
    logic           cell_val = 1'b0;
    logic [0:SX-1]  maze [SY-1:0];
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [0:SX-1]  m_maze [SY];
    logic [0:SX-1]  m_buf;
    int             m_phase = 0;
    int             m_row = 0;
    int             m_wpos = 0;

    logic [0:SX-1]  golden [SY];

    // load monitor
    bit track = 1'b0;
    int cyc = 0;
    int done_cnt = 0;
    int done_at = 0;
    int commit_low = 0;
    int accepts = 0;

    maze_loader #(
        .size_y (SY),
        .size_x (SX),
        .WORD_W (WW)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cell_we  (cell_we),
        .cell_x   (cell_x),
        .cell_y   (cell_y),
        .cell_val (cell_val),
        .maze     (maze),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [WW-1:0] word_of(input int k);
        return (k % 2 == 0) ? 8'hA5 : 8'h3C;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic we, input logic [5:0] x,
                                 input logic [4:0] y, input logic v,
                                 input logic vld, input logic [WW-1:0] d);
        @(posedge Clk);
        #2;
        start    = st;
        cell_we  = we;
        cell_x   = x;
        cell_y   = y;
        cell_val = v;
        in_valid = vld;
        in_data  = d;
    endtask

    // Behavioural model: a load is a sequence of rows, each WPR accepted words then one commit cycle.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            foreach (m_maze[r]) m_maze[r] = '0;
            m_buf   = '0;
            m_phase = 0;
            m_row   = 0;
            m_wpos  = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (start) begin
                        m_phase = 1;
                        m_row   = 0;
                        m_wpos  = 0;
                        m_buf   = '0;
                    end else if (cell_we && cell_x < 6'(SX) && cell_y < 5'(SY)) begin
                        m_maze[cell_y][cell_x] = cell_val;
                    end
                end
                1: begin
                    if (in_valid) begin
                        for (int i = 0; i < WW; i++) m_buf[m_wpos*WW + i] = in_data[WW-1-i];
                        m_wpos++;
                        if (m_wpos == WPR) begin
                            m_wpos  = 0;
                            m_phase = 2;
                        end
                    end
                end
                2: begin
                    m_maze[m_row] = m_buf;
                    if (m_row == SY - 1) m_phase = 3;
                    else begin
                        m_row++;
                        m_phase = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge Clk) begin
        int bad;
        bad = 0;
        for (int r = SY - 1; r >= 0; r--) if (maze[r] !== m_maze[r]) bad = r;
        checkOutput("in_ready", 64'(in_ready), 64'(m_phase == 1));
        checkOutput("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
        checkOutput("done", 64'(done), 64'(m_phase == 3));
        checkOutput($sformatf("maze row %0d", bad), 64'(maze[bad]), 64'(m_maze[bad]));
    end

    // Count load events: cycles since the first LOAD cycle, done pulses, commit bubbles, accepts.
    always @(negedge Clk) begin
        if (track) begin
            cyc++;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (busy && !in_ready) commit_low++;
            if (in_valid && in_ready) accepts++;
        end
    end

    task automatic do_load(input int max_gap, input int restart_at, input int abort_at,
                           input bit collide, input bit timed);
        bit acc;
        int guard;
        int any_set;
        applyStimulus(1'b1, collide, 6'd1, 5'd0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b1, word_of(0));
        track = 1'b1; cyc = 0; done_cnt = 0; done_at = 0; commit_low = 0; accepts = 0;
        if (collide) begin
            checkOutput("collide busy", 64'(busy), 64'd1);
            checkOutput("collide cell", 64'(maze[0][1]), 64'd0);
        end
        for (int k = 0; k < NWORDS; k++) begin
            if (k == abort_at) begin
                in_valid = 1'b0;
                Reset_n  = 1'b0;
                #1;
                any_set = 0;
                foreach (maze[r]) if (|maze[r]) any_set = 1;
                checkOutput("reset maze", 64'(any_set), 64'd0);
                checkOutput("reset in_ready", 64'(in_ready), 64'd0);
                checkOutput("reset busy", 64'(busy), 64'd0);
                checkOutput("reset done", 64'(done), 64'd0);
                checkOutput("accepts before abort", 64'(accepts), 64'(abort_at));
                repeat (2) begin @(posedge Clk); #2; end
                Reset_n = 1'b1;
                track   = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = word_of(k);
            if (k == restart_at) start = 1'b1;
            if (collide && k == 60) begin
                cell_we = 1'b1; cell_x = 6'd2; cell_y = 5'd0; cell_val = 1'b0;
            end
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                @(negedge Clk);
                acc = in_ready;
                guard++;
                @(posedge Clk);
                #2;
                start   = 1'b0;
                cell_we = 1'b0;
            end
            if (!acc) begin
                checkOutput("accept timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                track = 1'b0;
                return;
            end
            in_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin @(posedge Clk); #2; end
        end
        in_valid = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            @(posedge Clk);
            #2;
            guard++;
        end
        repeat (3) begin @(posedge Clk); #2; end
        checkOutput("done pulses", 64'(done_cnt), 64'd1);
        checkOutput("accepts", 64'(accepts), 64'd100);
        checkOutput("commit in_ready low", 64'(commit_low), 64'd20);
        if (timed) checkOutput("done cycle", 64'(done_at), 64'd121);
        track = 1'b0;
    endtask

    task automatic check_golden(input string name);
        int bad;
        bad = 0;
        for (int r = SY - 1; r >= 0; r--) if (maze[r] !== golden[r]) bad = r;
        checkOutput($sformatf("%s row %0d", name, bad), 64'(maze[bad]), 64'(golden[bad]));
    endtask

    // Directed test sequence.
    initial begin
        #1 Reset_n = 1'b0;
        repeat (3) begin @(posedge Clk); #2; end
        checkOutput("por in_ready", 64'(in_ready), 64'd0);
        checkOutput("por busy", 64'(busy), 64'd0);
        checkOutput("por done", 64'(done), 64'd0);
        checkOutput("por maze row0", 64'(maze[0]), 64'd0);
        Reset_n = 1'b1;
        $display("[TB] full load, no stalls, start re-pulsed at row 10");
        do_load(0, 50, -1, 1'b0, 1'b1);
        checkOutput("row0 word0", 64'(maze[0][0:7]), 64'(8'b10100101));
        checkOutput("row0 word1", 64'(maze[0][8:15]), 64'(8'b00111100));
        checkOutput("row1 word0", 64'(maze[1][0:7]), 64'(8'h3C));
        checkOutput("model row0 word0", 64'(m_maze[0][0:7]), 64'(8'hA5));
        checkOutput("model row19 tail", 64'(m_maze[19][32:39]), 64'(8'h3C));
        foreach (golden[r]) golden[r] = m_maze[r];
        $display("[TB] cell writes in IDLE");
        applyStimulus(1'b0, 1'b1, 6'd39, 5'd19, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0, '0);
        checkOutput("cell 39,19", 64'(maze[19][39]), 64'd1);
        applyStimulus(1'b0, 1'b1, 6'd40, 5'd0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 6'd0, 5'd20, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0, '0);
        checkOutput("oob row0", 64'(maze[0]), 64'(golden[0]));
        $display("[TB] stalled load with start/cell_we collision");
        do_load(5, -1, -1, 1'b1, 1'b0);
        check_golden("stalled load");
        $display("[TB] reset mid-load at row 7");
        do_load(0, -1, 37, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0, '0);
        checkOutput("idle after reset", 64'(busy), 64'd0);
        do_load(0, -1, -1, 1'b0, 1'b1);
        check_golden("reload");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
